memory_master_queue: RTL and testbench
======================================

# memory_master_queue

Host-command-driven master for the memory bus, replacing the single-shot command master used for bring-up. A 32-bit command word (8-bit opcode, 24-bit field) from the soft processor or debug host loads request registers, issues requests and reads back responses. Additions over the previous generation:
- parametrised address, data and ID widths;
- a response FIFO instead of a single response slot;
- address auto-increment for streaming;
- request fields held stable while a request is in flight.

## Interface
Parameters:
- ADDR_WIDTH, 32, request address width, 1..48; loaded as lower 24 bits plus upper bits.
- DATA_WIDTH, 24, data width, 1..24.
- ID_WIDTH, 8, transaction ID width, 1..24.
- RX_DEPTH, 4, response FIFO entries, a power of two, at least 2.

Ports:
- clock  in  1  single clock; all logic on its rising edge.
- resetN  in  1  asynchronous, active-low reset.
- in  in  32  command word: opcode in [31:24], field in [23:0].
- out  out  32  readback value, zero-extended.
- msAddress  out  ADDR_WIDTH  request address.
- msData  out  DATA_WIDTH  request write data.
- msID  out  ID_WIDTH  request ID.
- msWrite  out  1  1 = write, 0 = read.
- msValid  out  1  request valid.
- msTaken  in  1  slave accepts the request.
- smData  in  DATA_WIDTH  response data.
- smID  in  ID_WIDTH  response ID.
- smValid  in  1  response valid.
- smTaken  out  1  this master accepts the response.

## Operation
Opcodes:
- 0 NONE.
- 1 ADDRESS_LOWER: address[23:0] = field.
- 2 ADDRESS_UPPER: address[ADDR_WIDTH-1:24] = field, truncated.
- 3 DATA.
- 4 ID.
- 5 WRITE: field[0].
- 6 SEND.
- 7 GET_PENDING.
- 8 GET_DATA.
- 9 GET_ID.
- 10 GET_VALID.
- 11 POP.
- 12 FLUSH.
- 13 STRIDE: stride = field.
- 14 GET_COUNT.
- Any other opcode acts as NONE.

Load opcodes (1–5, 13):
- Write their register every cycle the opcode is present.
- Ignored while msValid=1, so the request is stable during the handshake.
- Fields are truncated to the register width.

SEND is edge-like:
- One request per continuous assertion of opcode SEND.
- An internal "sent" flag sets on handshake and clears on any cycle the opcode is not SEND.
- On the clock edge where opcode=SEND, msValid=0 and sent=0: msValid sets to 1.

On handshake (msValid && msTaken):
- msValid clears.
- sent sets.
- msAddress becomes msAddress + stride, modulo 2^ADDR_WIDTH. Stride 0 disables auto-increment.

Response acceptance:
- smTaken = (smID == msID) && !full && opcode != FLUSH. Combinational.
- On smValid && smTaken, {smData, smID} is pushed into the FIFO.

POP is edge-like, using a separate "popped" flag with the same rule as SEND. It removes the head entry once; POP on an empty FIFO does nothing.

FLUSH empties the FIFO on every cycle it is present.

Readback on out, combinational from the opcode, zero-extended:
- GET_PENDING: msValid.
- GET_DATA: head data.
- GET_ID: head ID.
- GET_VALID: FIFO non-empty.
- GET_COUNT: FIFO occupancy, 0..RX_DEPTH.
- All other opcodes: 0.
- GET_DATA and GET_ID on an empty FIFO return 0.

## Timing
- Reset values (resetN low, asynchronous): msValid=0, msAddress=0, msData=0, msID=0, msWrite=0, stride=0, sent=0, popped=0, FIFO empty.
- out=0 and smTaken=(smID==0) while in=0.
- Reset asserted mid-request drops msValid immediately; the request is abandoned.
- Request latency: msValid rises on the first edge with SEND; the earliest handshake is at the next edge.
- msTaken held high: the request completes one cycle after msValid rises. msValid stays low while SEND stays asserted.
- Push and pop in the same cycle on a non-empty FIFO: count unchanged; head advances; new entry written at the tail.
- Push and pop in the same cycle on an empty FIFO: pop ignored, push proceeds.
- Full FIFO: smTaken=0, and the response stalls on the bus. No overflow, no loss.
- Read pointers and write pointers wrap modulo RX_DEPTH.
- Occupancy counter is log2(RX_DEPTH)+1 bits.
- FLUSH has priority over push; any pop in the same cycle is moot.
- GET_* readback is valid in the same cycle as the opcode, with no register stage.

## Test plan
- Reset, then ID=5, ADDRESS_LOWER=0x000100, DATA=0xABCDEF, WRITE=1, SEND held 5 cycles, msTaken after 2 cycles -> exactly one handshake; address=0x100, data=0xABCDEF, write=1; GET_PENDING reads 0 afterwards.
- STRIDE=4, SEND pulsed 3 times with msTaken tied high -> addresses 0x100, 0x104, 0x108; msAddress=0x10C at the end.
- ADDRESS_LOWER=0x000200 while msValid=1 and msTaken low -> msAddress stays 0x10C until the handshake.
- 5 responses with smID=5 and RX_DEPTH=4 -> 4 accepted; smTaken=0 for the 5th; GET_COUNT=4. One POP -> 5th accepted, GET_COUNT=4, GET_DATA=2nd response.
- Response with smID=6 while ID=5 -> smTaken=0, FIFO unchanged. FLUSH -> GET_VALID=0, GET_COUNT=0.
- resetN pulsed low mid-handshake -> msValid=0 within the same cycle, FIFO empty, all registers 0.

Source files
------------

// File: rtl/memory_master_queue.sv
// Host-command-driven memory bus master: command words load request registers,
// launch one request per SEND assertion and queue matching responses in a FIFO.
module memory_master_queue #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 24,
    parameter int ID_WIDTH   = 8,
    parameter int RX_DEPTH   = 4
) (
    input  logic                  clock,
    input  logic                  resetN,
    input  logic [31:0]           in,
    output logic [31:0]           out,
    output logic [ADDR_WIDTH-1:0] msAddress,
    output logic [DATA_WIDTH-1:0] msData,
    output logic [ID_WIDTH-1:0]   msID,
    output logic                  msWrite,
    output logic                  msValid,
    input  logic                  msTaken,
    input  logic [DATA_WIDTH-1:0] smData,
    input  logic [ID_WIDTH-1:0]   smID,
    input  logic                  smValid,
    output logic                  smTaken
);

    localparam logic [7:0] OP_ADDR_LO  = 8'd1;
    localparam logic [7:0] OP_ADDR_HI  = 8'd2;
    localparam logic [7:0] OP_DATA     = 8'd3;
    localparam logic [7:0] OP_ID       = 8'd4;
    localparam logic [7:0] OP_WRITE    = 8'd5;
    localparam logic [7:0] OP_SEND     = 8'd6;
    localparam logic [7:0] OP_PENDING  = 8'd7;
    localparam logic [7:0] OP_GET_DATA = 8'd8;
    localparam logic [7:0] OP_GET_ID   = 8'd9;
    localparam logic [7:0] OP_GET_VLD  = 8'd10;
    localparam logic [7:0] OP_POP      = 8'd11;
    localparam logic [7:0] OP_FLUSH    = 8'd12;
    localparam logic [7:0] OP_STRIDE   = 8'd13;
    localparam logic [7:0] OP_GET_CNT  = 8'd14;

    localparam int PW = $clog2(RX_DEPTH);
    localparam int CW = PW + 1;

    logic [7:0]            w_op;
    logic [23:0]           w_field;
    logic [ADDR_WIDTH-1:0] w_addr_lower;
    logic [ADDR_WIDTH-1:0] w_addr_upper;
    logic                  w_handshake;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_push;
    logic                  w_pop;

    logic [23:0]           r_stride;
    logic                  r_sent;
    logic                  r_popped;
    logic [PW-1:0]         r_rd_ptr;
    logic [PW-1:0]         r_wr_ptr;
    logic [CW-1:0]         r_count;
    logic [DATA_WIDTH-1:0] r_fifo_data [RX_DEPTH];
    logic [ID_WIDTH-1:0]   r_fifo_id   [RX_DEPTH];

    assign w_op    = in[31:24];
    assign w_field = in[23:0];

    // Address bits above 23 only exist for wide buses; narrow buses drop the upper load.
    generate
        if (ADDR_WIDTH > 24) begin : g_wide_addr
            localparam int UW = ADDR_WIDTH - 24;
            assign w_addr_lower = {msAddress[ADDR_WIDTH-1:24], w_field};
            assign w_addr_upper = {UW'(w_field), msAddress[23:0]};
        end else begin : g_narrow_addr
            assign w_addr_lower = ADDR_WIDTH'(w_field);
            assign w_addr_upper = msAddress;
        end
    endgenerate

    assign w_handshake = msValid && msTaken;
    assign w_full      = (r_count == CW'(RX_DEPTH));
    assign w_empty     = (r_count == '0);
    assign smTaken     = (smID == msID) && !w_full && (w_op != OP_FLUSH);
    assign w_push      = smValid && smTaken;
    assign w_pop       = (w_op == OP_POP) && !r_popped && !w_empty;

    // Request side: loads are frozen while a request is outstanding.
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            msAddress <= '0;
            msData    <= '0;
            msID      <= '0;
            msWrite   <= 1'b0;
            msValid   <= 1'b0;
            r_stride  <= '0;
            r_sent    <= 1'b0;
        end else begin
            if (w_op != OP_SEND) begin
                r_sent <= 1'b0;
            end else if (w_handshake) begin
                r_sent <= 1'b1;
            end

            if (w_handshake) begin
                msValid   <= 1'b0;
                msAddress <= msAddress + ADDR_WIDTH'(r_stride);
            end else if (!msValid) begin
                case (w_op)
                    OP_ADDR_LO: msAddress <= w_addr_lower;
                    OP_ADDR_HI: msAddress <= w_addr_upper;
                    OP_DATA:    msData    <= DATA_WIDTH'(w_field);
                    OP_ID:      msID      <= ID_WIDTH'(w_field);
                    OP_WRITE:   msWrite   <= w_field[0];
                    OP_STRIDE:  r_stride  <= w_field;
                    OP_SEND:    msValid   <= !r_sent;
                    default:    ;
                endcase
            end
        end
    end

    // Response FIFO control; FLUSH overrides any push or pop in the same cycle.
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
            r_popped <= 1'b0;
        end else begin
            r_popped <= (w_op == OP_POP);
            if (w_op == OP_FLUSH) begin
                r_rd_ptr <= '0;
                r_wr_ptr <= '0;
                r_count  <= '0;
            end else begin
                if (w_push) begin
                    r_wr_ptr <= r_wr_ptr + 1'b1;
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + 1'b1;
                end
                r_count <= r_count + CW'(w_push) - CW'(w_pop);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (w_push) begin
            r_fifo_data[r_wr_ptr] <= smData;
            r_fifo_id[r_wr_ptr]   <= smID;
        end
    end

    always_comb begin
        out = '0;
        case (w_op)
            OP_PENDING:  out = {31'd0, msValid};
            OP_GET_DATA: out = w_empty ? '0 : 32'(r_fifo_data[r_rd_ptr]);
            OP_GET_ID:   out = w_empty ? '0 : 32'(r_fifo_id[r_rd_ptr]);
            OP_GET_VLD:  out = {31'd0, !w_empty};
            OP_GET_CNT:  out = 32'(r_count);
            default:     out = '0;
        endcase
    end

endmodule

// File: tb/tb_memory_master_queue.sv
// Directed bench for memory_master_queue: request scoreboard checked by a bus
// monitor, response scoreboard checked against FIFO readback.
module tb_memory_master_queue;

    logic        clock;
    logic        resetN;
    logic [31:0] in;
    logic [31:0] out;
    logic [31:0] msAddress;
    logic [23:0] msData;
    logic [7:0]  msID;
    logic        msWrite;
    logic        msValid;
    logic        msTaken;
    logic [23:0] smData;
    logic [7:0]  smID;
    logic        smValid;
    logic        smTaken;

    int checks = 0;
    int errors = 0;
    int handshakes = 0;

    // Request entries: {address, data, id, write}
    logic [64:0] exp_q[$];
    logic [23:0] rsp_q[$];

    memory_master_queue dut (
        .clock     (clock),
        .resetN    (resetN),
        .in        (in),
        .out       (out),
        .msAddress (msAddress),
        .msData    (msData),
        .msID      (msID),
        .msWrite   (msWrite),
        .msValid   (msValid),
        .msTaken   (msTaken),
        .smData    (smData),
        .smID      (smID),
        .smValid   (smValid),
        .smTaken   (smTaken)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [64:0] obs, input logic [64:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic cmd(input logic [7:0] op, input logic [23:0] field);
        in = {op, field};
        tick();
    endtask

    task automatic peek(input logic [7:0] op, input string tag, input logic [31:0] exp);
        in = {op, 24'd0};
        #1;
        check(tag, 65'(out), 65'(exp));
    endtask

    // A handshake is sampled at the falling edge before the edge that completes it.
    always @(negedge clock) begin
        if (resetN && msValid && msTaken) begin
            handshakes++;
            if (exp_q.size() == 0) begin
                check("unexpected_request", 65'(msAddress), 65'h1_dead_beef);
            end else begin
                check("request_fields", {msAddress, msData, msID, msWrite}, exp_q.pop_front());
            end
        end
    end

    initial begin
        logic [23:0] d;
        resetN  = 1'b0;
        in      = '0;
        msTaken = 1'b0;
        smData  = '0;
        smID    = '0;
        smValid = 1'b0;
        #2;
        check("reset_msValid", 65'(msValid), 65'd0);
        check("reset_msAddress", 65'(msAddress), 65'd0);
        check("reset_out", 65'(out), 65'd0);
        check("reset_smTaken", 65'(smTaken), 65'd1);
        tick();
        tick();
        resetN = 1'b1;
        tick();

        // Single request with delayed msTaken while SEND is held five cycles
        cmd(8'd4, 24'd5);
        cmd(8'd1, 24'h000100);
        cmd(8'd3, 24'hABCDEF);
        cmd(8'd5, 24'd1);
        exp_q.push_back({32'h100, 24'hABCDEF, 8'd5, 1'b1});
        cmd(8'd6, 24'd0);
        check("send_latency", 65'(msValid), 65'd1);
        cmd(8'd6, 24'd0);
        check("send_waiting", 65'(msValid), 65'd1);
        msTaken = 1'b1;
        cmd(8'd6, 24'd0);
        check("send_done", 65'(msValid), 65'd0);
        cmd(8'd6, 24'd0);
        cmd(8'd6, 24'd0);
        check("send_no_repeat", 65'(msValid), 65'd0);
        check("one_handshake", 65'(handshakes), 65'd1);
        check("addr_no_stride", 65'(msAddress), 65'h100);
        peek(8'd7, "get_pending_idle", 32'd0);

        // Stride of 4 with msTaken tied high
        msTaken = 1'b0;
        cmd(8'd13, 24'd4);
        msTaken = 1'b1;
        for (int k = 0; k < 3; k++) begin
            exp_q.push_back({32'h100 + 32'(4 * k), 24'hABCDEF, 8'd5, 1'b1});
            cmd(8'd6, 24'd0);
            cmd(8'd0, 24'd0);
        end
        check("stride_handshakes", 65'(handshakes), 65'd4);
        check("stride_final_addr", 65'(msAddress), 65'h10C);

        // Loads are ignored while a request is pending
        msTaken = 1'b0;
        exp_q.push_back({32'h10C, 24'hABCDEF, 8'd5, 1'b1});
        cmd(8'd6, 24'd0);
        cmd(8'd1, 24'h000200);
        check("addr_hold_1", 65'(msAddress), 65'h10C);
        cmd(8'd1, 24'h000200);
        check("addr_hold_2", 65'(msAddress), 65'h10C);
        peek(8'd7, "get_pending_busy", 32'd1);
        msTaken = 1'b1;
        cmd(8'd0, 24'd0);
        msTaken = 1'b0;
        check("addr_after_hs", 65'(msAddress), 65'h110);

        // Fill the response FIFO with matching IDs; the fifth stalls
        smID    = 8'd5;
        smValid = 1'b1;
        in      = '0;
        for (int i = 0; i < 5; i++) begin
            d = 24'($urandom_range(0, 24'hFFFFFF));
            smData = d;
            @(negedge clock);
            check("fill_smTaken", 65'(smTaken), (i < 4) ? 65'd1 : 65'd0);
            if (i < 4) begin
                rsp_q.push_back(d);
                tick();
            end
        end
        peek(8'd14, "count_full", 32'd4);
        cmd(8'd11, 24'd0);
        void'(rsp_q.pop_front());
        in = {8'd14, 24'd0};
        #1;
        check("fifth_accept", 65'(smTaken), 65'd1);
        rsp_q.push_back(smData);
        tick();
        smValid = 1'b0;
        peek(8'd14, "count_after_pop", 32'd4);
        peek(8'd8, "head_second", 32'(rsp_q[0]));
        peek(8'd9, "head_id", 32'd5);
        peek(8'd10, "get_valid", 32'd1);

        // POP held two cycles removes only one entry
        cmd(8'd11, 24'd0);
        cmd(8'd11, 24'd0);
        void'(rsp_q.pop_front());
        peek(8'd14, "pop_once_count", 32'd3);
        peek(8'd8, "pop_once_head", 32'(rsp_q[0]));

        // Mismatched ID is not accepted
        smID    = 8'd6;
        smValid = 1'b1;
        smData  = 24'h123456;
        in      = '0;
        #1;
        check("id_mismatch", 65'(smTaken), 65'd0);
        tick();
        smID = 8'd5;
        peek(8'd12, "flush_blocks_take", 32'd0);
        check("flush_smTaken", 65'(smTaken), 65'd0);
        peek(8'd14, "count_mismatch", 32'd3);
        smValid = 1'b0;

        cmd(8'd12, 24'd0);
        rsp_q.delete();
        peek(8'd10, "flush_valid", 32'd0);
        peek(8'd14, "flush_count", 32'd0);
        peek(8'd8, "empty_data", 32'd0);
        cmd(8'd11, 24'd0);
        peek(8'd14, "pop_empty", 32'd0);

        // Reset in the middle of a request abandons it
        smValid = 1'b1;
        smData  = 24'h00BEEF;
        cmd(8'd6, 24'd0);
        smValid = 1'b0;
        check("pre_reset_valid", 65'(msValid), 65'd1);
        msTaken = 1'b1;
        resetN  = 1'b0;
        #1;
        check("rst_msValid", 65'(msValid), 65'd0);
        check("rst_fields", {msAddress, msData, msID, msWrite}, 65'd0);
        peek(8'd14, "rst_count", 32'd0);
        tick();
        msTaken = 1'b0;
        resetN  = 1'b1;
        in      = '0;
        tick();

        check("total_handshakes", 65'(handshakes), 65'd5);
        check("exp_q_drained", 65'(exp_q.size()), 65'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
